// File: rtl/gmux_bklt_pwm.sv
// ---------------------------------------------------------------------------
// gmux_bklt_pwm
//
// LCD backlight PWM generator for the gMUX bypass CPLD. Two board buttons
// (up/down, active low) step a saturating brightness level; the level maps
// to a quadratic duty curve. The new duty is applied only at PWM period
// boundaries, so the pulse train never glitches. The pin is gated by the
// iGPU backlight-on signal.
//
// Ports
//   LPC_CLK33M_GMUX  in   single clock, rising edge
//   GMUX_RST         in   synchronous active-high reset
//   BTN_UP_L         in   brightness up, active low, asynchronous
//   BTN_DN_L         in   brightness down, active low, asynchronous
//   LVDS_IG_BKL_ON   in   backlight enable, asynchronous
//   LCD_BKLT_PWM     out  registered PWM drive
//   BKLT_LEVEL       out  current brightness level (LW bits)
//   BKLT_DUTY        out  duty in slices currently driven (DW bits)
//
// Build option
//   GMUX_BKLT_FADE_EN  when defined, the active duty walks one slice per
//                      period toward the target instead of jumping to it.
// ---------------------------------------------------------------------------
module gmux_bklt_pwm #(
  parameter int PWM_DIV         = 2,
  parameter int PWM_PERIOD      = 100,
  parameter int NUM_LEVELS      = 17,
  parameter int MIN_LEVEL       = 1,
  parameter int DEFAULT_LEVEL   = 10,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_CYCLES   = 16777216,
  localparam int LW = $clog2(NUM_LEVELS),
  localparam int DW = $clog2(PWM_PERIOD + 1)
) (
  input  logic          LPC_CLK33M_GMUX,
  input  logic          GMUX_RST,
  input  logic          BTN_UP_L,
  input  logic          BTN_DN_L,
  input  logic          LVDS_IG_BKL_ON,
  output logic          LCD_BKLT_PWM,
  output logic [LW-1:0] BKLT_LEVEL,
  output logic [DW-1:0] BKLT_DUTY
);

  // -------------------------------------------------------------------------
  // Derived widths and constants
  // -------------------------------------------------------------------------
  localparam int PW    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int SW    = $clog2(PWM_PERIOD);
  localparam int DBW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int LUT_N = 1 << LW;

  localparam logic [PW-1:0]  PRESC_MAX = PW'(PWM_DIV - 1);
  localparam logic [SW-1:0]  SLICE_MAX = SW'(PWM_PERIOD - 1);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RPT_MAX   = RW'(REPEAT_CYCLES - 1);
  localparam logic [LW-1:0]  LVL_MAX   = LW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0]  LVL_MIN   = LW'(MIN_LEVEL);
  localparam logic [LW-1:0]  LVL_RST   = LW'(DEFAULT_LEVEL);

  // Perceptual (quadratic) brightness curve evaluated at elaboration time.
  // 64-bit intermediates comfortably exceed 2*LW+DW bits for any sane
  // parameter set, so L*L*PWM_PERIOD never overflows. Any non-zero level is
  // forced to at least one slice so it stays visibly distinct from "off".
  function automatic logic [DW-1:0] target_of(input int lvl);
    longint unsigned num;
    longint unsigned den;
    longint unsigned q;
    if (lvl <= 0 || lvl >= NUM_LEVELS) begin
      return '0;
    end
    num = longint'(lvl) * longint'(lvl) * longint'(PWM_PERIOD);
    den = longint'(NUM_LEVELS - 1) * longint'(NUM_LEVELS - 1);
    q   = num / den;
    if (q == 0) begin
      q = 1;
    end
    return DW'(q);
  endfunction

  localparam logic [DW-1:0] DUTY_RST = target_of(DEFAULT_LEVEL);

  // -------------------------------------------------------------------------
  // Level -> duty lookup. Entries past NUM_LEVELS-1 are unreachable and
  // tie to 0; padding to a power of two keeps the index in range.
  // -------------------------------------------------------------------------
  logic [DW-1:0] duty_lut [0:LUT_N-1];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    assign duty_lut[gi] = target_of(gi);
  end

  // -------------------------------------------------------------------------
  // Button front end: synchroniser, debouncer, press edge and auto-repeat.
  // Index 0 is the up button, index 1 the down button.
  // -------------------------------------------------------------------------
  logic [1:0] btn_raw_l;
  logic [1:0] btn_held;   // debounced "pressed"
  logic [1:0] btn_press;  // one-cycle pulse on debounced press
  logic [1:0] btn_rpt;    // one-cycle auto-repeat pulse

  assign btn_raw_l = {BTN_DN_L, BTN_UP_L};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic           sync1_q,   sync1_d;
    logic           sync2_q,   sync2_d;
    logic [DBW-1:0] db_cnt_q,  db_cnt_d;
    logic           db_q,      db_d;
    logic           db_prev_q, db_prev_d;
    logic [RW-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic           rpt_fire;

    always_comb begin
      sync1_d   = btn_raw_l[gi];
      sync2_d   = sync1_q;
      db_cnt_d  = db_cnt_q;
      db_d      = db_q;
      db_prev_d = db_q;
      rpt_cnt_d = rpt_cnt_q;

      // Debounce: the synchronised input must disagree with the accepted
      // state for DEBOUNCE_CYCLES consecutive clocks before it is taken.
      if ((!sync2_q) == db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_MAX) begin
        db_d     = ~db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end

      // The repeat counter holds at 0 during the press-edge cycle so the
      // first repeat lands exactly REPEAT_CYCLES clocks after the initial
      // step, then every REPEAT_CYCLES clocks after that.
      rpt_fire = db_q && db_prev_q && (rpt_cnt_q == RPT_MAX);
      if (!db_q || !db_prev_q || rpt_fire) begin
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end

    always_ff @(posedge LPC_CLK33M_GMUX) begin
      if (GMUX_RST) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        db_cnt_q  <= '0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        rpt_cnt_q <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        db_cnt_q  <= db_cnt_d;
        db_q      <= db_d;
        db_prev_q <= db_prev_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign btn_held[gi]  = db_q;
    assign btn_press[gi] = db_q & ~db_prev_q;
    assign btn_rpt[gi]   = rpt_fire;
  end

  // -------------------------------------------------------------------------
  // Backlight enable synchroniser
  // -------------------------------------------------------------------------
  logic en_s1_q, en_s1_d;
  logic en_s2_q, en_s2_d;

  always_comb begin
    en_s1_d = LVDS_IG_BKL_ON;
    en_s2_d = en_s1_q;
  end

  // -------------------------------------------------------------------------
  // Level update. Holding both buttons freezes auto-repeat; simultaneous
  // steps in opposite directions cancel.
  // -------------------------------------------------------------------------
  logic          both_held;
  logic          up_step;
  logic          dn_step;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    both_held = btn_held[0] & btn_held[1];
    up_step   = btn_press[0] | (btn_rpt[0] & ~both_held);
    dn_step   = btn_press[1] | (btn_rpt[1] & ~both_held);
    level_d   = level_q;
    if (up_step && !dn_step) begin
      if (level_q < LVL_MAX) begin
        level_d = level_q + LW'(1);
      end
    end else if (dn_step && !up_step) begin
      if (level_q > LVL_MIN) begin
        level_d = level_q - LW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Slice timebase: prescaler produces tick, slice counter walks the period.
  // -------------------------------------------------------------------------
  logic          tick;
  logic          boundary;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] slice_q, slice_d;

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (slice_q == SLICE_MAX);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    slice_d  = slice_q;
    if (tick) begin
      slice_d = (slice_q == SLICE_MAX) ? '0 : slice_q + SW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Active duty and PWM output. The duty register only moves on the last
  // tick of a period, so the new value first applies at slice 0.
  // -------------------------------------------------------------------------
  logic [DW-1:0] target;
  logic [DW-1:0] duty_q, duty_d;
  logic          pwm_q,  pwm_d;

  always_comb begin
    target = duty_lut[level_q];
    duty_d = duty_q;
    if (boundary) begin
`ifdef GMUX_BKLT_FADE_EN
      if (duty_q < target) begin
        duty_d = duty_q + DW'(1);
      end else if (duty_q > target) begin
        duty_d = duty_q - DW'(1);
      end
`else
      duty_d = target;
`endif
    end
    // Duty 0 never satisfies the compare, duty PWM_PERIOD always does.
    pwm_d = en_s2_q && (DW'(slice_q) < duty_q);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge LPC_CLK33M_GMUX) begin
    if (GMUX_RST) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      level_q <= LVL_RST;
      presc_q <= '0;
      slice_q <= '0;
      duty_q  <= DUTY_RST;
      pwm_q   <= 1'b0;
    end else begin
      en_s1_q <= en_s1_d;
      en_s2_q <= en_s2_d;
      level_q <= level_d;
      presc_q <= presc_d;
      slice_q <= slice_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign LCD_BKLT_PWM = pwm_q;
  assign BKLT_LEVEL   = level_q;
  assign BKLT_DUTY    = duty_q;

endmodule
